serial_word_assembler: RTL and testbench

- Upstream feeder for the bit-reversal stage.
- Collects a serial bitstream, LSB first, into DATA_WIDTH-bit words and presents each completed word on a registered valid/ready output.
- The downstream bit-reverser consumes dout directly.
- Supports backpressure and a flush that emits a partial, zero-padded word.

---
 rtl/bitops_pkg.sv | 19 +
 rtl/word_out_reg.sv | 54 +++++
 rtl/serial_word_assembler.sv | 114 +++++++++++
 tb/tb_serial_word_assembler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bitops_pkg.sv
// Types and constants shared by the serial word assembler and the bit-reversal stage.
package bitops_pkg;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } asm_state_e;

   localparam int DEFAULT_DATA_WIDTH = 32;

   // Width able to hold a bit count from 0 up to and including w.
   function automatic int cnt_width(input int w);
      if (w < 1) begin
         return 1;
      end
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/word_out_reg.sv
// Output holding register for assembled words: dout/dout_len/dout_valid with a
// valid/ready handshake. "free" reports that a new word may load this cycle.
module word_out_reg #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_W      = 6
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic [CNT_W-1:0]      load_len,
   input  logic                  dout_ready,
   output logic [DATA_WIDTH-1:0] dout,
   output logic [CNT_W-1:0]      dout_len,
   output logic                  dout_valid,
   output logic                  free
);

   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic [CNT_W-1:0]      len_q, len_d;
   logic                  valid_q, valid_d;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dout_q  <= '0;
         len_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         dout_q  <= dout_d;
         len_q   <= len_d;
         valid_q <= valid_d;
      end
   end

   // A word draining this cycle makes room for a new one on the same edge.
   always_comb begin
      free    = !valid_q || dout_ready;
      dout_d  = dout_q;
      len_d   = len_q;
      valid_d = valid_q;
      if (load) begin
         dout_d  = load_data;
         len_d   = load_len;
         valid_d = 1'b1;
      end else if (valid_q && dout_ready) begin
         valid_d = 1'b0;
      end
   end

   assign dout       = dout_q;
   assign dout_len   = len_q;
   assign dout_valid = valid_q;

endmodule

// File: rtl/serial_word_assembler.sv
// Collects an LSB-first serial bitstream into words; supports backpressure and
// a flush that closes a partial, zero-padded word.
module serial_word_assembler
   import bitops_pkg::*;
#(
   parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
   localparam int CNT_W      = cnt_width(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  din,
   input  logic                  din_valid,
   output logic                  din_ready,
   input  logic                  flush,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic [CNT_W-1:0]      dout_len
);

   asm_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d, eff_cnt;
   logic [DATA_WIDTH-1:0] acc_q, acc_d, acc_w;
   logic                  accept, close_word, out_free, load;
   logic [DATA_WIDTH-1:0] load_data;
   logic [CNT_W-1:0]      load_len;

   assign accept  = din_valid && din_ready;
   assign eff_cnt = cnt_q + CNT_W'(accept);

   // Bit position equals arrival order; the accumulator is never shifted.
   for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_acc_bit
      assign acc_w[gi] = (accept && (cnt_q == CNT_W'(gi))) ? din : acc_q[gi];
   end

   assign close_word = (state_q == COLLECT) &&
                       ((eff_cnt == CNT_W'(DATA_WIDTH)) || (flush && (eff_cnt != '0)));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= COLLECT;
         cnt_q   <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      case (state_q)
         COLLECT: begin
            if (close_word && out_free) begin
               cnt_d = '0;
               acc_d = '0;
            end else begin
               cnt_d = eff_cnt;
               acc_d = acc_w;
               if (close_word) begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (out_free) begin
               state_d = COLLECT;
               cnt_d   = '0;
               acc_d   = '0;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_comb begin
      din_ready = 1'b0;
      load      = 1'b0;
      load_data = acc_w;
      load_len  = eff_cnt;
      case (state_q)
         COLLECT: begin
            din_ready = 1'b1;
            load      = close_word && out_free;
         end
         HOLD: begin
            load      = out_free;
            load_data = acc_q;
            load_len  = cnt_q;
         end
         default: ;
      endcase
   end

   word_out_reg #(
      .DATA_WIDTH(DATA_WIDTH),
      .CNT_W     (CNT_W)
   ) u_out (
      .clk       (clk),
      .resetn    (resetn),
      .load      (load),
      .load_data (load_data),
      .load_len  (load_len),
      .dout_ready(dout_ready),
      .dout      (dout),
      .dout_len  (dout_len),
      .dout_valid(dout_valid),
      .free      (out_free)
   );

endmodule

// File: tb/tb_serial_word_assembler.sv
// Randomized and directed bench for serial_word_assembler (DATA_WIDTH=8) with a
// queue-based behavioural model checked every cycle.
module tb_serial_word_assembler;

   localparam int W = 8;

   logic         clk;
   logic         resetn;
   logic         din;
   logic         din_valid;
   logic         din_ready;
   logic         flush;
   logic [W-1:0] dout;
   logic         dout_valid;
   logic         dout_ready;
   logic [3:0]   dout_len;

   int pass_cnt  = 0;
   int total_cnt = 0;

   serial_word_assembler #(.DATA_WIDTH(W)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .flush     (flush),
      .dout      (dout),
      .dout_valid(dout_valid),
      .dout_ready(dout_ready),
      .dout_len  (dout_len)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: pending bits kept in a queue, output as a plain word.
   bit         m_bits[$];
   logic       m_hold;
   logic       m_ov;
   logic [7:0] m_dout;
   logic [3:0] m_len;

   function automatic logic [7:0] pack_bits();
      logic [7:0] w = '0;
      for (int i = 0; i < m_bits.size(); i++) begin
         w[i] = m_bits[i];
      end
      return w;
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge resetn);
         if (!resetn) begin
            m_bits.delete();
            m_hold = 1'b0;
            m_ov   = 1'b0;
            m_dout = '0;
            m_len  = '0;
         end else begin
            bit free_now;
            bit load_now;
            free_now = !m_ov || dout_ready;
            load_now = 1'b0;
            if (!m_hold) begin
               if (din_valid) m_bits.push_back(din);
               if (m_bits.size() == W || (flush && m_bits.size() > 0)) begin
                  if (free_now) load_now = 1'b1;
                  else m_hold = 1'b1;
               end
            end else if (free_now) begin
               load_now = 1'b1;
            end
            if (load_now) begin
               m_dout = pack_bits();
               m_len  = 4'(m_bits.size());
               m_ov   = 1'b1;
               m_bits.delete();
               m_hold = 1'b0;
            end else if (m_ov && dout_ready) begin
               m_ov = 1'b0;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (resetn) begin
            chk("din_ready", din_ready, !m_hold);
            chk("dout_valid", dout_valid, m_ov);
            chk("dout", dout, m_dout);
            chk("dout_len", dout_len, m_len);
         end
      end
   end

   task automatic tick(input logic v, input logic b, input logic f, input logic r);
      din_valid  = v;
      din        = b;
      flush      = f;
      dout_ready = r;
      @(negedge clk);
      #1;
   endtask

   task automatic send_word(input logic [7:0] w, input logic r);
      for (int i = 0; i < W; i++) tick(1'b1, w[i], 1'b0, r);
   endtask

   logic [7:0] words[4];
   logic [7:0] seen_w[$];
   int         seen_t[$];

   initial begin
      resetn = 1'b0; din = 1'b0; din_valid = 1'b0; flush = 1'b0; dout_ready = 1'b0;
      #3;
      chk("rst_din_ready", din_ready, 1);
      chk("rst_dout_valid", dout_valid, 0);
      chk("rst_dout", dout, 0);
      chk("rst_dout_len", dout_len, 0);
      @(negedge clk); @(negedge clk); #1;
      resetn = 1'b1;

      // Basic word: bits 1,0,1,1,0,0,0,0 -> 0x0D
      tick(1, 1, 0, 1); tick(1, 0, 0, 1); tick(1, 1, 0, 1); tick(1, 1, 0, 1);
      tick(1, 0, 0, 1); tick(1, 0, 0, 1); tick(1, 0, 0, 1);
      chk("basic_not_yet", dout_valid, 0);
      tick(1, 0, 0, 1);
      chk("basic_valid", dout_valid, 1);
      chk("basic_dout", dout, 8'h0D);
      chk("basic_len", dout_len, 8);
      tick(0, 0, 0, 1);
      chk("basic_one_cycle", dout_valid, 0);

      // Backpressure into HOLD
      send_word(8'hFF, 1'b0);
      chk("bp_first_dout", dout, 8'hFF);
      for (int i = 0; i < 7; i++) tick(1, (i == 0) ? 1'b1 : 1'b0, 0, 0);
      chk("bp_ready_before", din_ready, 1);
      tick(1, 1, 0, 0);
      chk("bp_ready_low", din_ready, 0);
      chk("bp_dout_held", dout, 8'hFF);
      tick(0, 0, 0, 1);
      chk("bp_dout_81", dout, 8'h81);
      chk("bp_valid", dout_valid, 1);
      chk("bp_ready_back", din_ready, 1);
      tick(0, 0, 0, 1);

      // Flush with same-cycle bit: 1,1,0,1 -> 0x0B, len 4
      tick(1, 1, 0, 1); tick(1, 1, 0, 1); tick(1, 0, 0, 1);
      tick(1, 1, 1, 1);
      chk("flush_dout", dout, 8'h0B);
      chk("flush_len", dout_len, 4);
      chk("flush_valid", dout_valid, 1);
      send_word(8'h5A, 1'b1);
      chk("after_flush_dout", dout, 8'h5A);
      chk("after_flush_len", dout_len, 8);

      // Flush with nothing collected is a no-op
      tick(0, 0, 1, 1);
      tick(0, 0, 0, 1);
      chk("empty_flush", dout_valid, 0);

      // Flush while in HOLD is ignored
      send_word(8'h3C, 1'b0);
      send_word(8'hC3, 1'b0);
      tick(1, 1, 1, 0);
      chk("hold_flush_ready", din_ready, 0);
      chk("hold_flush_dout", dout, 8'h3C);
      tick(0, 0, 0, 1);
      chk("hold_out_dout", dout, 8'hC3);
      chk("hold_out_len", dout_len, 8);
      tick(0, 0, 0, 1);
      chk("hold_no_extra", dout_valid, 0);
      tick(0, 0, 0, 1);
      chk("hold_no_extra2", dout_valid, 0);

      // Reset mid-operation
      send_word(8'h77, 1'b0);
      for (int i = 0; i < 5; i++) tick(1, 1, 0, 0);
      din_valid = 1'b0; flush = 1'b0; dout_ready = 1'b0;
      #2 resetn = 1'b0;
      #1;
      chk("mid_rst_valid", dout_valid, 0);
      chk("mid_rst_dout", dout, 0);
      chk("mid_rst_len", dout_len, 0);
      @(negedge clk); #1;
      resetn = 1'b1;
      send_word(8'hA5, 1'b1);
      chk("post_rst_dout", dout, 8'hA5);
      chk("post_rst_valid", dout_valid, 1);
      tick(0, 0, 0, 1);

      // Streaming: 4 words back-to-back, 8-cycle spacing
      for (int k = 0; k < 4; k++) words[k] = 8'($urandom);
      for (int t = 0; t < 33; t++) begin
         if (t < 32) begin
            logic [7:0] w;
            w = words[t / 8];
            tick(1, w[t % 8], 0, 1);
         end else begin
            tick(0, 0, 0, 1);
         end
         if (dout_valid) begin
            seen_w.push_back(dout);
            seen_t.push_back(t);
         end
      end
      chk("stream_count", seen_w.size(), 4);
      for (int k = 0; k < seen_w.size() && k < 4; k++) begin
         chk("stream_word", seen_w[k], words[k]);
         chk("stream_time", seen_t[k], 8 * k + 7);
      end

      // Random stress against the model
      for (int i = 0; i < 1500; i++) begin
         tick($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 15) == 0,
              $urandom_range(0, 3) != 0);
      end
      tick(0, 0, 0, 1);
      tick(0, 0, 0, 1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
